bram1_dual_arbiter: RTL and testbench

- Shares one single-ported, optionally output-pipelined block RAM between two requesters (port 0, port 1).
- Arbitrates round-robin, issues at most one access per cycle to the BRAM, and tracks in-flight reads.
- Each read result is returned on the response port of the requester that issued it.
- Sits between two pipeline clients (e.g. fetch and memory stages) and the BRAM instance.

---
 rtl/bram1_dual_arbiter.sv | 98 +++++++++
 tb/tb_bram1_dual_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bram1_dual_arbiter.sv
// Round-robin arbiter sharing one single-ported BRAM between two requesters.
// Read results are routed back to the issuing port after the BRAM read latency.
module bram1_dual_arbiter #(
    parameter int PIPELINED  = 1,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 512
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int LAT = (PIPELINED != 0) ? 2 : 1;

    // Handshake: a request is accepted when reqN_valid && reqN_ready in the
    // same cycle; responses are one-cycle pulses with no backpressure.
    logic           prio_q, prio_d;
    logic [LAT-1:0] trk_vld_q, trk_vld_d;
    logic [LAT-1:0] trk_id_q, trk_id_d;
    logic           gnt_vld;
    logic           gnt_id;
    logic           acc_we;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (RST_N) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = prio_q;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_vld & ~gnt_id;
    assign req1_ready = gnt_vld & gnt_id;
    assign acc_we     = gnt_id ? req1_we : req0_we;

    // With no grant gnt_id is 0, so the idle address/data follow port 0.
    assign bram_en   = gnt_vld;
    assign bram_we   = gnt_vld & acc_we;
    assign bram_addr = gnt_id ? req1_addr : req0_addr;
    assign bram_di   = gnt_id ? req1_data : req0_data;

    always_comb begin
        prio_d       = gnt_vld ? ~gnt_id : prio_q;
        trk_vld_d    = '0;
        trk_id_d     = '0;
        trk_vld_d[0] = gnt_vld & ~acc_we;
        trk_id_d[0]  = gnt_id;
        for (int i = 1; i < LAT; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1];
            trk_id_d[i]  = trk_id_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prio_q    <= 1'b0;
            trk_vld_q <= '0;
            trk_id_q  <= '0;
        end else begin
            prio_q    <= prio_d;
            trk_vld_q <= trk_vld_d;
            trk_id_q  <= trk_id_d;
        end
    end

    // Reads issued before a reset must never surface, even with LAT = 1.
    assign resp0_valid = RST_N & trk_vld_q[LAT-1] & ~trk_id_q[LAT-1];
    assign resp1_valid = RST_N & trk_vld_q[LAT-1] & trk_id_q[LAT-1];
    assign resp0_data  = bram_do;
    assign resp1_data  = bram_do;

endmodule

// File: tb/tb_bram1_dual_arbiter.sv
// Bench driving a pipelined (a_) and a non-pipelined (b_) arbiter with the same
// request stream; each has its own behavioural BRAM and response scoreboard.
module tb_bram1_dual_arbiter;

    localparam int AW = 7;
    localparam int DW = 512;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;

    logic          a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid;
    logic [DW-1:0] a_resp0_data, a_resp1_data, a_bram_di, a_bram_do;
    logic          a_bram_en, a_bram_we;
    logic [AW-1:0] a_bram_addr;
    logic          b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid;
    logic [DW-1:0] b_resp0_data, b_resp1_data, b_bram_di, b_bram_do;
    logic          b_bram_en, b_bram_we;
    logic [AW-1:0] b_bram_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // index 0/1: pipelined build ports 0/1; index 2/3: non-pipelined build
    logic [DW-1:0] exp_q[4][$];
    int            exp_cyc_q[4][$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    bram1_dual_arbiter #(.PIPELINED(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
        .CLK(clk), .RST_N(rst_n),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .resp0_valid(a_resp0_valid), .resp0_data(a_resp0_data),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .resp1_valid(a_resp1_valid), .resp1_data(a_resp1_data),
        .bram_en(a_bram_en), .bram_we(a_bram_we), .bram_addr(a_bram_addr),
        .bram_di(a_bram_di), .bram_do(a_bram_do)
    );

    bram1_dual_arbiter #(.PIPELINED(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_b (
        .CLK(clk), .RST_N(rst_n),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .resp0_valid(b_resp0_valid), .resp0_data(b_resp0_data),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .resp1_valid(b_resp1_valid), .resp1_data(b_resp1_data),
        .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_addr(b_bram_addr),
        .bram_di(b_bram_di), .bram_do(b_bram_do)
    );

    // ---------------- BRAM models (read-first) ----------------
    logic [DW-1:0] mem_a [0:127];
    logic [DW-1:0] mem_b [0:127];
    logic [DW-1:0] a_rd_q, a_rd_q2, b_rd_q;

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = DW'(32'hA0 + i);
            mem_b[i] = DW'(32'hA0 + i);
        end
        mem_a[3] = DW'(32'h77);
        mem_b[3] = DW'(32'h77);
    end

    always @(posedge clk) begin
        if (a_bram_en) begin
            if (a_bram_we) mem_a[a_bram_addr] <= a_bram_di;
            a_rd_q <= mem_a[a_bram_addr];
        end
        a_rd_q2 <= a_rd_q;
        if (b_bram_en) begin
            if (b_bram_we) mem_b[b_bram_addr] <= b_bram_di;
            b_rd_q <= mem_b[b_bram_addr];
        end
    end
    assign a_bram_do = a_rd_q2;
    assign b_bram_do = b_rd_q;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_resp(input int k, input logic v, input logic [DW-1:0] d);
        logic [DW-1:0] ed;
        int            ec;
        if (v === 1'b1) begin
            checks++;
            if (exp_q[k].size() == 0) begin
                failures++;
                $display("FAIL resp%0d unexpected: got data %0h at cycle %0d expected none", k, d, cyc);
            end else begin
                ed = exp_q[k].pop_front();
                ec = exp_cyc_q[k].pop_front();
                if (d !== ed || cyc != ec) begin
                    failures++;
                    $display("FAIL resp%0d: got data %0h cycle %0d expected data %0h cycle %0d",
                             k, d, cyc, ed, ec);
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        check_resp(0, a_resp0_valid, a_resp0_data);
        check_resp(1, a_resp1_valid, a_resp1_data);
        check_resp(2, b_resp0_valid, b_resp0_data);
        check_resp(3, b_resp1_valid, b_resp1_data);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic rst,
                        input logic v0, input logic w0, input int a0, input logic [DW-1:0] d0,
                        input logic v1, input logic w1, input int a1, input logic [DW-1:0] d1,
                        input logic er0, input logic er1, input string tag);
        @(posedge clk);
        #1;
        rst_n      = rst;
        req0_valid = v0;
        req0_we    = w0;
        req0_addr  = AW'(a0);
        req0_data  = d0;
        req1_valid = v1;
        req1_we    = w1;
        req1_addr  = AW'(a1);
        req1_data  = d1;
        @(negedge clk);
        chk({tag, " a_rdy0"}, DW'(a_req0_ready), DW'(er0));
        chk({tag, " a_rdy1"}, DW'(a_req1_ready), DW'(er1));
        chk({tag, " b_rdy0"}, DW'(b_req0_ready), DW'(er0));
        chk({tag, " b_rdy1"}, DW'(b_req1_ready), DW'(er1));
        chk({tag, " a_en"}, DW'(a_bram_en), DW'(er0 | er1));
        chk({tag, " b_en"}, DW'(b_bram_en), DW'(er0 | er1));
    endtask

    // Called in the accept cycle: pipelined build answers 2 cycles later, the other 1.
    task automatic expect_rd(input int port, input logic [DW-1:0] d);
        exp_q[port].push_back(d);
        exp_cyc_q[port].push_back(cyc + 2);
        exp_q[port+2].push_back(d);
        exp_cyc_q[port+2].push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, 0, 0, 0, '0, 0, 0, "idle");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_data = '0;

        // reset holds readies and the BRAM enable low even with requests pending
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, '0, 1, 0, 2, '0, 0, 0, "reset");
        chk("reset a_resp0", DW'(a_resp0_valid), '0);
        chk("reset a_resp1", DW'(a_resp1_valid), '0);
        chk("reset b_resp0", DW'(b_resp0_valid), '0);
        chk("reset b_resp1", DW'(b_resp1_valid), '0);

        // contention right after reset: p0 first, then alternate
        step(1, 1, 0, 1, '0, 1, 0, 2, '0, 1, 0, "cont1"); expect_rd(0, DW'(32'hA1));
        step(1, 1, 0, 1, '0, 1, 0, 2, '0, 0, 1, "cont2"); expect_rd(1, DW'(32'hA2));
        step(1, 1, 0, 1, '0, 1, 0, 2, '0, 1, 0, "cont3"); expect_rd(0, DW'(32'hA1));
        step(1, 1, 0, 1, '0, 1, 0, 2, '0, 0, 1, "cont4"); expect_rd(1, DW'(32'hA2));

        // single read latency
        step(1, 1, 0, 5, '0, 0, 0, 0, '0, 1, 0, "lat"); expect_rd(0, DW'(32'hA5));
        idle(3);

        // write then read same address from port 1
        step(1, 0, 0, 0, '0, 1, 1, 9, DW'(32'h1234), 0, 1, "wr9");
        step(1, 0, 0, 0, '0, 1, 0, 9, '0, 0, 1, "rd9"); expect_rd(1, DW'(32'h1234));

        // streaming reads from port 0
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, i, '0, 0, 0, 0, '0, 1, 0, "stream");
            expect_rd(0, (i == 3) ? DW'(32'h77) : DW'(32'hA0 + i));
        end
        idle(3);

        // reset mid-flight drops the read and restores port 0 priority
        step(1, 1, 0, 4, '0, 0, 0, 0, '0, 1, 0, "mf_rd");
        step(0, 1, 0, 6, '0, 1, 0, 7, '0, 0, 0, "mf_rst");
        step(1, 1, 0, 6, '0, 1, 0, 7, '0, 1, 0, "mf_p0"); expect_rd(0, DW'(32'hA6));
        step(1, 0, 0, 0, '0, 1, 0, 7, '0, 0, 1, "mf_p1"); expect_rd(1, DW'(32'hA7));

        // contested write on p0 vs read on p1 of the same address
        step(1, 1, 1, 20, DW'(32'hBEEF), 1, 0, 20, '0, 1, 0, "mix_wr");
        step(1, 0, 0, 0, '0, 1, 0, 20, '0, 0, 1, "mix_rd"); expect_rd(1, DW'(32'hBEEF));

        idle(5);
        for (int k = 0; k < 4; k++)
            chk($sformatf("drain q%0d", k), DW'(exp_q[k].size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
